// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter for the shared 32-bit 2:1 operand mux.
// Grants one source at a time, bounds bursts, registers the selected word.
module mux_bus_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             last0,
    input  logic             last1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    logic [1:0]    state, state_n;
    logic          prio, prio_n;
    logic [CW-1:0] beat_cnt, cnt_n;
    logic          beat;
    logic          burst_end;
    logic          side;
    logic          cur_req;
    logic          cur_last;
    logic          other_req;

    assign gnt0 = (state == GRANT0);
    assign gnt1 = (state == GRANT1);
    assign sel  = (state == GRANT1);

    always_comb begin
        state_n   = state;
        prio_n    = prio;
        cnt_n     = beat_cnt;
        beat      = 1'b0;
        burst_end = 1'b0;
        side      = 1'b0;
        cur_req   = 1'b0;
        cur_last  = 1'b0;
        other_req = 1'b0;
        case (state)
            GRANT0: begin
                side      = 1'b0;
                cur_req   = req0;
                cur_last  = last0;
                other_req = req1;
            end
            GRANT1: begin
                side      = 1'b1;
                cur_req   = req1;
                cur_last  = last1;
                other_req = req0;
            end
            default: ;
        endcase

        if (state == GRANT0 || state == GRANT1) begin
            beat      = cur_req;
            burst_end = cur_req & (cur_last | (beat_cnt == LAST_CNT));
            if (beat)
                cnt_n = beat_cnt + 1'b1;
            // A dropped request releases the grant at once; last is ignored
            if (burst_end || !beat) begin
                prio_n = ~side;
                if (other_req) begin
                    state_n = side ? GRANT0 : GRANT1;
                    cnt_n   = '0;
                end else if (burst_end) begin
                    cnt_n = '0;
                end else begin
                    state_n = IDLE;
                end
            end
        end else begin
            cnt_n = '0;
            if (req0 && req1)
                state_n = prio ? GRANT1 : GRANT0;
            else if (req0)
                state_n = GRANT0;
            else if (req1)
                state_n = GRANT1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            beat_cnt  <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            prio      <= prio_n;
            beat_cnt  <= cnt_n;
            out_valid <= beat;
            if (beat)
                out <= sel ? data1 : data0;
        end
    end

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Directed vector bench for mux_bus_arbiter.
// Inputs change 1 time unit after each rising edge; outputs checked there.
module tb_mux_bus_arbiter;

    localparam int W = 32;
    localparam logic [W-1:0] D0 = 32'hF0F0F0F0;
    localparam logic [W-1:0] D1 = 32'h0F0F0F0F;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1, last0, last1;
    logic [W-1:0] data0, data1;
    logic         gnt0, gnt1, sel, out_valid;
    logic [W-1:0] out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         r0, r1, l0, l1, rs;
        logic         g0, g1, v;
        logic [W-1:0] o;
    } vec_t;

    vec_t vecs[$];

    mux_bus_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .last0(last0), .last1(last1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
        .out(out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r0, r1, l0, l1, rs,
                       input logic g0, g1, v, input logic [W-1:0] o);
        vec_t t;
        t.r0 = r0; t.r1 = r1; t.l0 = l0; t.l1 = l1; t.rs = rs;
        t.g0 = g0; t.g1 = g1; t.v = v; t.o = o;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r0, r1, l0, l1, rs);
        req0 = r0; req1 = r1; last0 = l0; last1 = l1; rst = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic g0, g1, v,
                              input logic [W-1:0] o);
        chk({tag, " gnt0"}, W'(gnt0), W'(g0));
        chk({tag, " gnt1"}, W'(gnt1), W'(g1));
        chk({tag, " sel"}, W'(sel), W'(g1));
        chk({tag, " out_valid"}, W'(out_valid), W'(v));
        chk({tag, " out"}, out, o);
        chk({tag, " onehot"}, W'(gnt0 & gnt1), '0);
    endtask

    initial begin
        rst = 1'b1; req0 = 0; req1 = 0; last0 = 0; last1 = 0;
        data0 = D0; data1 = D1;

        // reset with both requests high, then tie goes to source 0
        add(1,1,0,0,1, 0,0,0,'0);
        add(1,1,0,0,1, 0,0,0,'0);
        add(1,1,0,0,0, 1,0,0,'0);
        // round robin: 4 beats each side, handover with no bubble
        add(1,1,0,0,0, 1,0,1,D0);
        add(1,1,0,0,0, 1,0,1,D0);
        add(1,1,0,0,0, 1,0,1,D0);
        add(1,1,0,0,0, 0,1,1,D0);
        add(1,1,0,0,0, 0,1,1,D1);
        add(1,1,0,0,0, 0,1,1,D1);
        add(1,1,0,0,0, 0,1,1,D1);
        add(1,1,0,0,0, 1,0,1,D1);
        add(1,1,0,0,0, 1,0,1,D0);
        add(1,1,0,0,0, 1,0,1,D0);
        add(1,1,0,0,0, 1,0,1,D0);
        add(1,1,0,0,0, 0,1,1,D0);
        // early end: last1 on the 2nd beat
        add(1,1,0,0,0, 0,1,1,D1);
        add(1,1,0,1,0, 1,0,1,D1);
        // release: req0 dropped mid-burst
        add(1,0,0,0,0, 1,0,1,D0);
        add(0,0,0,0,0, 0,0,0,D0);
        add(0,0,0,0,0, 0,0,0,D0);
        // single source 0: 4 beats then re-grant with no gap
        add(1,0,0,0,0, 1,0,0,D0);
        add(1,0,0,0,0, 1,0,1,D0);
        add(1,0,0,0,0, 1,0,1,D0);
        add(1,0,0,0,0, 1,0,1,D0);
        add(1,0,0,0,0, 1,0,1,D0);
        add(1,0,0,0,0, 1,0,1,D0);
        add(1,0,0,0,0, 1,0,1,D0);
        // reset on the 3rd beat; prio was 1, must return to 0
        add(1,0,0,0,1, 0,0,0,'0);
        add(1,1,0,0,0, 1,0,0,'0);
        // last coincident with burst limit: single end
        add(1,1,0,0,0, 1,0,1,D0);
        add(1,1,0,0,0, 1,0,1,D0);
        add(1,1,0,0,0, 1,0,1,D0);
        add(1,1,1,0,0, 0,1,1,D0);
        add(1,1,0,0,0, 0,1,1,D1);

        foreach (vecs[i]) begin
            drive(vecs[i].r0, vecs[i].r1, vecs[i].l0, vecs[i].l1, vecs[i].rs);
            expect_out($sformatf("v%0d", i), vecs[i].g0, vecs[i].g1,
                       vecs[i].v, vecs[i].o);
        end

        // last1 without a beat is a release, not a burst end
        drive(0,0,0,0,1);
        drive(0,1,0,0,0);
        expect_out("h1 grant1", 0,1,0,'0);
        drive(0,0,0,1,0);
        expect_out("h1 release", 0,0,0,'0);
        drive(1,0,0,0,0);
        expect_out("h1 grant0", 1,0,0,'0);
        // release from GRANT0 hands the next tie to source 1
        drive(0,0,0,0,0);
        expect_out("h2 release", 0,0,0,'0);
        drive(1,1,0,0,0);
        expect_out("h2 tie", 0,1,0,'0);
        drive(1,1,0,0,0);
        expect_out("h2 beat", 0,1,1,D1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_bus_arbiter.md
# mux_bus_arbiter

Round-robin arbiter and sequencer for the shared 32-bit operand path built on the 2:1 `MUX32b` select. Two requesters compete for the path. The block grants one at a time, drives the mux select, and bounds each burst. It also registers the selected word with a valid strobe for the downstream stage. It sits between the two data sources and the consumer of the muxed bus in the single-cycle datapath.

## Interface
- `WIDTH`, 32, data width of each source and of the output.
- `MAX_BURST`, 4, maximum beats per grant (must be ≥1).

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  request from source 0 / 1; a beat occurs on each cycle where the source is granted and its request is high.
- `last0` / `last1`  in  1  qualifies a beat as the final beat of the burst.
- `data0` / `data1`  in  WIDTH  source words.
- `gnt0` / `gnt1`  out  1  grant, one-hot or zero.
- `sel`  out  1  mux control: 0 selects `data0`, 1 selects `data1`.
- `out`  out  WIDTH  registered selected word.
- `out_valid`  out  1  `out` was loaded by a beat on the previous edge.

## Operation
- **State:**
  - `state` ∈ {IDLE, GRANT0, GRANT1}.
  - `prio` (1 bit): the side that wins a tie.
  - `beat_cnt`: width clog2(MAX_BURST)+1.
- **Decoded outputs (Moore, from `state`):**
  - `gnt0` = (state==GRANT0).
  - `gnt1` = (state==GRANT1).
  - `sel` = (state==GRANT1).
- **IDLE:**
  - One requester high → go to its GRANT.
  - Both high → go to GRANT[`prio`].
  - Neither high → stay in IDLE.
  - `beat_cnt` ← 0 on entry to any GRANT.
- **GRANTx, beat (`reqx`=1):**
  - `out` ← `datax`, `out_valid` ← 1, `beat_cnt` ← `beat_cnt`+1.
  - The burst ends if `lastx`=1 or `beat_cnt`==MAX_BURST-1.
- **GRANTx, no beat (`reqx`=0):**
  - `out` holds, `out_valid` ← 0.
  - The grant is released immediately.
- **On burst end or release:**
  - `prio` ← other side.
  - Next state:
    - Other side's `req` high → GRANT(other), with no idle bubble.
    - Otherwise, if the burst ended with `reqx` still high → GRANTx again, with `beat_cnt` restarting at 0.
    - Otherwise → IDLE.
- **Burst continues:** stay in GRANTx; `prio` is unchanged.
- **`out_valid`:** 0 on any cycle without a beat; `out` retains its last value.
- **Width rules:** `beat_cnt` never exceeds MAX_BURST-1 at a compare. With MAX_BURST=1, every beat ends the grant.

## Timing
- **Reset values:**
  - `state`=IDLE, `prio`=0, `beat_cnt`=0.
  - `gnt0`=`gnt1`=0, `sel`=0.
  - `out`=0, `out_valid`=0.
- **Latency:**
  - `req` high in cycle N from IDLE → grant asserted in cycle N+1.
  - First beat in cycle N+1 → `out`/`out_valid` visible in cycle N+2.
- **Handover:** on a burst end in cycle M with the other side requesting, the other grant is asserted in cycle M+1. There is no dead cycle.
- **Simultaneous events:**
  - Both requests rising together from IDLE: `prio` decides.
  - `last` asserted together with the burst limit: treated as a single burst end.
- **`last` without beat:** `lastx` while `reqx`=0 is ignored; the release rule applies.
- **Reset mid-burst:**
  - In the cycle after `rst`, all grants are 0 and `out_valid`=0.
  - The beat sampled on the reset edge is discarded.
  - `prio` returns to 0.
- **Grant invariant:** `gnt0`&`gnt1` is never 1.

## Test plan
- **Reset:** assert `rst` 2 cycles with both requests high → all outputs 0. After release: `gnt0`=1 at the next edge, `sel`=0.
- **Single source 0:**
  - Stimulus: `data0`=F0F0F0F0, `req0` held high, `last0`=0, MAX_BURST=4.
  - Required: 4 beats with `out`=F0F0F0F0 and `out_valid`=1, then `gnt0` is re-granted with no gap.
- **Round-robin:**
  - Stimulus: both requests held high, `data1`=0F0F0F0F.
  - Required: `gnt0` for 4 cycles, then `gnt1` for 4 cycles, with `sel` toggling 0→1→0 and `out` alternating F0F0F0F0 / 0F0F0F0F in 4-beat runs.
- **Early end via `last1`:**
  - Stimulus: `last1` asserted on the 2nd beat of a source-1 burst while `req0` is high.
  - Required: `gnt0` in the next cycle; `out`=0F0F0F0F for exactly 2 valid beats.
- **Release:**
  - Stimulus: `req0` dropped mid-burst with `req1` low.
  - Required: `out_valid`=0 and `out` holding its last value on the output cycle after the drop, then IDLE with both grants 0.
- **Reset mid-burst:** `rst` asserted on the 3rd beat → the next cycle shows both grants 0 and `out_valid`=0; a subsequent tie is granted to source 0.
